// File: rtl/clock_divider_pkg.sv
// Shared definitions for the clock divider bank: default sizes, the
// per-channel action encoding, and small helpers for index width and
// half-period sanitising.
package clock_divider_pkg;

  localparam int CNT_W_DEFAULT   = 16;
  localparam int DEFAULT_DIV_VAL = 5000;

  // What a channel does on the coming clock edge.
  typedef enum logic [1:0] {
    CH_HOLD  = 2'd0,  // disabled: keep cnt/clk_out, tick low
    CH_COUNT = 2'd1,  // running, not at terminal count
    CH_WRAP  = 2'd2,  // running, terminal count: toggle and restart
    CH_ALIGN = 2'd3   // realign strobe: zero everything, apply pending
  } ch_action_e;

  // Width of the channel-select field; never narrower than one bit.
  function automatic int ch_idx_w(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

  // A half-period of zero would never reach terminal count; treat it as 1.
  function automatic logic [31:0] hp_sanitize(input logic [31:0] v);
    if (v == 32'd0) begin
      return 32'd1;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/clock_divider_ch.sv
// One divider channel: half-period register, counter, deferred-load
// register with its pending flag, and registered clk_out/tick.
module clock_divider_ch
  import clock_divider_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int DEFAULT_DIV = DEFAULT_DIV_VAL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             ld,
  input  logic [CNT_W-1:0] ld_div,
  output logic             clk_out,
  output logic             tick,
  output logic [CNT_W-1:0] cnt,
  output logic             pend
);

  localparam logic [CNT_W-1:0] HP_RST = CNT_W'(hp_sanitize(32'(DEFAULT_DIV)));

  logic [CNT_W-1:0] hp_r;
  logic [CNT_W-1:0] nxt_r;
  logic [CNT_W-1:0] div_s;
  logic [CNT_W-1:0] hp_new_s;
  logic             term_s;
  ch_action_e       action_s;

  // Decode this cycle's action; sync wins over terminal count and loads.
  always_comb begin
    div_s    = CNT_W'(hp_sanitize(32'(ld_div)));
    // >= rather than == so a corrupted counter still wraps instead of running away
    term_s   = (cnt >= (hp_r - {{(CNT_W-1){1'b0}}, 1'b1}));
    action_s = CH_HOLD;
    if (sync) begin
      action_s = CH_ALIGN;
    end else if (!en) begin
      action_s = CH_HOLD;
    end else if (term_s) begin
      action_s = CH_WRAP;
    end else begin
      action_s = CH_COUNT;
    end
    // Half-period taking effect at a boundary: a same-cycle load beats a pending one.
    if (ld) begin
      hp_new_s = div_s;
    end else if (pend) begin
      hp_new_s = nxt_r;
    end else begin
      hp_new_s = hp_r;
    end
  end

  // Channel state update.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      hp_r    <= HP_RST;
      nxt_r   <= HP_RST;
      pend    <= 1'b0;
    end else begin
      case (action_s)
        CH_ALIGN: begin
          cnt     <= '0;
          clk_out <= 1'b0;
          tick    <= 1'b0;
          hp_r    <= hp_new_s;
          pend    <= 1'b0;
        end
        CH_WRAP: begin
          cnt     <= '0;
          clk_out <= ~clk_out;
          tick    <= 1'b1;
          hp_r    <= hp_new_s;
          pend    <= 1'b0;
        end
        CH_COUNT: begin
          cnt  <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          tick <= 1'b0;
          if (ld) begin
            nxt_r <= div_s;
            pend  <= 1'b1;
          end
        end
        CH_HOLD: begin
          tick <= 1'b0;
          // A load into a stopped channel takes effect at once and restarts the count.
          if (ld) begin
            hp_r <= div_s;
            cnt  <= '0;
          end
        end
        default: begin
          tick <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/clock_divider_bank.sv
// NUM_CH independent 50%-duty clock dividers with a shared valid/ready
// load port. Optional feature macro: CLK_DIV_SYNC_EN adds the sync port,
// which realigns every channel in one cycle.
module clock_divider_bank
  import clock_divider_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int DEFAULT_DIV = DEFAULT_DIV_VAL
) (
  input  logic                            clk_in,
  input  logic                            rst,
  input  logic [NUM_CH-1:0]               en,
  input  logic                            ld_valid,
  input  logic [ch_idx_w(NUM_CH)-1:0]     ld_ch,
  input  logic [CNT_W-1:0]                ld_div,
  output logic                            ld_ready,
  output logic [NUM_CH-1:0]               clk_out,
  output logic [NUM_CH-1:0]               tick,
  output logic [NUM_CH*CNT_W-1:0]         count
`ifdef CLK_DIV_SYNC_EN
  ,
  input  logic                            sync
`endif
);

  logic [NUM_CH-1:0] pend_s;
  logic [NUM_CH-1:0] ld_hit_s;
  logic              sync_s;
  logic              accept_s;

`ifdef CLK_DIV_SYNC_EN
  assign sync_s = sync;
`else
  assign sync_s = 1'b0;
`endif

  // Ready follows the addressed channel's pending flag; out-of-range
  // channels always accept and the request is dropped.
  always_comb begin
    ld_ready = 1'b1;
    if (32'(ld_ch) < 32'(NUM_CH)) begin
      ld_ready = ~pend_s[ld_ch];
    end else begin
      ld_ready = 1'b1;
    end
  end

  assign accept_s = ld_valid & ld_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ld_hit_s[i] = accept_s & (32'(ld_ch) == i);

    clock_divider_ch #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk     (clk_in),
      .rst     (rst),
      .en      (en[i]),
      .sync    (sync_s),
      .ld      (ld_hit_s[i]),
      .ld_div  (ld_div),
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .cnt     (count[i*CNT_W +: CNT_W]),
      .pend    (pend_s[i])
    );
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed, table-driven bench for clock_divider_bank (NUM_CH=4, CNT_W=16,
// DEFAULT_DIV=5000). Build with CLK_DIV_SYNC_EN to also exercise sync.
module tb_clock_divider_bank;

  logic        clk_in = 1'b0;
  logic        rst;
  logic [3:0]  en;
  logic        ld_valid;
  logic [1:0]  ld_ch;
  logic [15:0] ld_div;
  logic        ld_ready;
  logic [3:0]  clk_out;
  logic [3:0]  tick;
  logic [63:0] count;
`ifdef CLK_DIV_SYNC_EN
  logic        sync;
`endif

  int checks = 0;
  int errors = 0;

  clock_divider_bank #(
    .NUM_CH      (4),
    .CNT_W       (16),
    .DEFAULT_DIV (5000)
  ) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .en       (en),
    .ld_valid (ld_valid),
    .ld_ch    (ld_ch),
    .ld_div   (ld_div),
    .ld_ready (ld_ready),
    .clk_out  (clk_out),
    .tick     (tick),
    .count    (count)
`ifdef CLK_DIV_SYNC_EN
    ,
    .sync     (sync)
`endif
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [3:0]  en;
    logic        ld_valid;
    logic [1:0]  ld_ch;
    logic [15:0] ld_div;
    int          ch;
    logic        e_ready;
    logic        e_clk;
    logic        e_tick;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] cnt_of(input int ch);
    return count[ch*16 +: 16];
  endfunction

  task automatic add(input logic [3:0] e, input logic v, input logic [1:0] c,
                     input logic [15:0] d, input int ch, input logic r,
                     input logic ck, input logic tk, input logic [15:0] cn);
    vec_t x;
    x.en = e; x.ld_valid = v; x.ld_ch = c; x.ld_div = d; x.ch = ch;
    x.e_ready = r; x.e_clk = ck; x.e_tick = tk; x.e_cnt = cn;
    vecs.push_back(x);
  endtask

  initial begin
    int first_tick;
    int tick_seen;

    rst = 1'b1; en = 4'b0000; ld_valid = 1'b0; ld_ch = 2'd0; ld_div = 16'd0;
`ifdef CLK_DIV_SYNC_EN
    sync = 1'b0;
`endif

    // Load ch1 hp=3 while stopped, then run: period 6
    add(4'b0000, 1'b1, 2'd1, 16'd3,  1, 1'b1, 1'b0, 1'b0, 16'd0);
    add(4'b0010, 1'b0, 2'd1, 16'd0,  1, 1'b1, 1'b0, 1'b0, 16'd1);
    add(4'b0010, 1'b0, 2'd1, 16'd0,  1, 1'b1, 1'b0, 1'b0, 16'd2);
    add(4'b0010, 1'b0, 2'd1, 16'd0,  1, 1'b1, 1'b1, 1'b1, 16'd0);
    add(4'b0010, 1'b0, 2'd1, 16'd0,  1, 1'b1, 1'b1, 1'b0, 16'd1);
    add(4'b0010, 1'b0, 2'd1, 16'd0,  1, 1'b1, 1'b1, 1'b0, 16'd2);
    add(4'b0010, 1'b0, 2'd1, 16'd0,  1, 1'b1, 1'b0, 1'b1, 16'd0);
    add(4'b0010, 1'b0, 2'd1, 16'd0,  1, 1'b1, 1'b0, 1'b0, 16'd1);
    // ch2: hp=10, deferred load of 4 at cnt=5
    add(4'b0010, 1'b1, 2'd2, 16'd10, 2, 1'b1, 1'b0, 1'b0, 16'd0);
    for (int k = 1; k <= 5; k++)
      add(4'b0110, 1'b0, 2'd2, 16'd0, 2, 1'b1, 1'b0, 1'b0, 16'(k));
    add(4'b0110, 1'b1, 2'd2, 16'd4,  2, 1'b1, 1'b0, 1'b0, 16'd6);
    add(4'b0110, 1'b0, 2'd2, 16'd0,  2, 1'b0, 1'b0, 1'b0, 16'd7);
    // requests while not ready must be ignored
    add(4'b0110, 1'b1, 2'd2, 16'd7,  2, 1'b0, 1'b0, 1'b0, 16'd8);
    add(4'b0110, 1'b1, 2'd2, 16'd7,  2, 1'b0, 1'b0, 1'b0, 16'd9);
    add(4'b0110, 1'b0, 2'd2, 16'd0,  2, 1'b0, 1'b1, 1'b1, 16'd0);
    add(4'b0110, 1'b0, 2'd2, 16'd0,  2, 1'b1, 1'b1, 1'b0, 16'd1);
    add(4'b0110, 1'b0, 2'd2, 16'd0,  2, 1'b1, 1'b1, 1'b0, 16'd2);
    add(4'b0110, 1'b0, 2'd2, 16'd0,  2, 1'b1, 1'b1, 1'b0, 16'd3);
    add(4'b0110, 1'b0, 2'd2, 16'd0,  2, 1'b1, 1'b0, 1'b1, 16'd0);
    add(4'b0110, 1'b0, 2'd2, 16'd0,  2, 1'b1, 1'b0, 1'b0, 16'd1);
    add(4'b0110, 1'b0, 2'd2, 16'd0,  2, 1'b1, 1'b0, 1'b0, 16'd2);
    add(4'b0110, 1'b0, 2'd2, 16'd0,  2, 1'b1, 1'b0, 1'b0, 16'd3);
    // load on the terminal-count cycle applies at that boundary
    add(4'b0110, 1'b1, 2'd2, 16'd2,  2, 1'b1, 1'b1, 1'b1, 16'd0);
    add(4'b0110, 1'b0, 2'd2, 16'd0,  2, 1'b1, 1'b1, 1'b0, 16'd1);
    add(4'b0110, 1'b0, 2'd2, 16'd0,  2, 1'b1, 1'b0, 1'b1, 16'd0);
    add(4'b0110, 1'b0, 2'd2, 16'd0,  2, 1'b1, 1'b0, 1'b0, 16'd1);
    // ch3: ld_div=0 behaves as 1, toggles every cycle
    add(4'b0110, 1'b1, 2'd3, 16'd0,  3, 1'b1, 1'b0, 1'b0, 16'd0);
    add(4'b1110, 1'b0, 2'd3, 16'd0,  3, 1'b1, 1'b1, 1'b1, 16'd0);
    add(4'b1110, 1'b0, 2'd3, 16'd0,  3, 1'b1, 1'b0, 1'b1, 16'd0);
    add(4'b1110, 1'b0, 2'd3, 16'd0,  3, 1'b1, 1'b1, 1'b1, 16'd0);

    // Reset state
    repeat (3) @(negedge clk_in);
    check("rst_clk_out", 32'(clk_out), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_count_lo", count[31:0], 32'd0);
    check("rst_count_hi", count[63:32], 32'd0);
    check("rst_ready", 32'(ld_ready), 32'd1);

    // Default divide on ch0: first tick 5000 cycles after release
    rst = 1'b0; en = 4'b0001;
    first_tick = -1;
    for (int n = 1; n <= 5100; n++) begin
      @(negedge clk_in);
      if (tick[0] && first_tick < 0) begin
        first_tick = n;
        break;
      end
    end
    check("default_first_tick", 32'(first_tick), 32'd5000);
    check("default_clk_out0", 32'(clk_out[0]), 32'd1);
    check("default_cnt0", 32'(cnt_of(0)), 32'd0);

    // Drop en[0] at cnt=7 for 20 cycles
    repeat (7) @(negedge clk_in);
    check("pre_hold_cnt0", 32'(cnt_of(0)), 32'd7);
    en = 4'b0000;
    tick_seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk_in);
      if (tick[0]) tick_seen = 1;
    end
    check("hold_cnt0", 32'(cnt_of(0)), 32'd7);
    check("hold_clk_out0", 32'(clk_out[0]), 32'd1);
    check("hold_tick0", 32'(tick_seen), 32'd0);
    en = 4'b0001;
    @(negedge clk_in);
    check("resume_cnt0", 32'(cnt_of(0)), 32'd8);
    en = 4'b0000;

    // Table-driven sequences
    for (int i = 0; i < vecs.size(); i++) begin
      en = vecs[i].en; ld_valid = vecs[i].ld_valid;
      ld_ch = vecs[i].ld_ch; ld_div = vecs[i].ld_div;
      #1;
      check($sformatf("row%0d_ready", i), 32'(ld_ready), 32'(vecs[i].e_ready));
      @(negedge clk_in);
      check($sformatf("row%0d_clk", i), 32'(clk_out[vecs[i].ch]), 32'(vecs[i].e_clk));
      check($sformatf("row%0d_tick", i), 32'(tick[vecs[i].ch]), 32'(vecs[i].e_tick));
      check($sformatf("row%0d_cnt", i), 32'(cnt_of(vecs[i].ch)), 32'(vecs[i].e_cnt));
    end
    ld_valid = 1'b0;

`ifdef CLK_DIV_SYNC_EN
    // Mixed phases plus a pending load on ch1, then a sync strobe
    en = 4'b0000; ld_valid = 1'b1; ld_ch = 2'd1; ld_div = 16'd3;
    @(negedge clk_in);
    ld_valid = 1'b0; en = 4'b1110;
    @(negedge clk_in);
    check("sync_pre_cnt1", 32'(cnt_of(1)), 32'd1);
    ld_valid = 1'b1; ld_div = 16'd5;
    @(negedge clk_in);
    ld_valid = 1'b0;
    #1;
    check("sync_pend_ready", 32'(ld_ready), 32'd0);
    sync = 1'b1;
    @(negedge clk_in);
    sync = 1'b0;
    check("sync_clk_out", 32'(clk_out), 32'd0);
    check("sync_tick", 32'(tick), 32'd0);
    check("sync_count_lo", count[31:0], 32'd0);
    check("sync_count_hi", count[63:32], 32'd0);
    check("sync_ready", 32'(ld_ready), 32'd1);
    repeat (4) @(negedge clk_in);
    check("sync_hp5_cnt1", 32'(cnt_of(1)), 32'd4);
    check("sync_hp5_notick", 32'(tick[1]), 32'd0);
    @(negedge clk_in);
    check("sync_hp5_tick", 32'(tick[1]), 32'd1);
    check("sync_hp5_clk", 32'(clk_out[1]), 32'd1);
`endif

    // Mid-run reset clears everything
    en = 4'b1111; ld_valid = 1'b1; ld_ch = 2'd0; ld_div = 16'd9;
    @(negedge clk_in);
    ld_valid = 1'b0; rst = 1'b1;
    @(negedge clk_in);
    check("mid_rst_clk_out", 32'(clk_out), 32'd0);
    check("mid_rst_tick", 32'(tick), 32'd0);
    check("mid_rst_count_lo", count[31:0], 32'd0);
    check("mid_rst_count_hi", count[63:32], 32'd0);
    for (int c = 0; c < 4; c++) begin
      ld_ch = 2'(c);
      #1;
      check($sformatf("mid_rst_ready%0d", c), 32'(ld_ready), 32'd1);
    end
    rst = 1'b0;
    @(negedge clk_in);
    check("post_rst_cnt0", 32'(cnt_of(0)), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
